// File: rtl/ticktocktokens_core.sv
// Time-multiplexed bank of token-counting processors. One addressed processor is
// read, updated and written back per cycle; start/stop tokens come out registered.
module ticktocktokens_core #(
  parameter int NUM_PROCESSORS    = 10,
  parameter int PROCESSOR_ID_BITS = 4,
  parameter int NEW_TOKENS_BITS   = 4,
  parameter int TOKENS_BITS       = 8,
  parameter int DURATION_BITS     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   instruction,
  input  logic [PROCESSOR_ID_BITS-1:0] processor_id,
  input  logic [NEW_TOKENS_BITS-1:0]   new_good_tokens,
  input  logic [NEW_TOKENS_BITS-1:0]   new_bad_tokens,
  input  logic [TOKENS_BITS-1:0]       prog_threshold,
  input  logic [DURATION_BITS-1:0]     prog_duration,
  output logic                         output_valid,
  output logic                         token_start,
  output logic                         token_stop,
  output logic [PROCESSOR_ID_BITS-1:0] output_id
);

  typedef enum logic [1:0] {
    INSTR_NOP   = 2'b00,
    INSTR_INIT  = 2'b01,
    INSTR_INPUT = 2'b10,
    INSTR_TICK  = 2'b11
  } instr_e;

  localparam logic signed [TOKENS_BITS-1:0] TOK_MAX = {1'b0, {(TOKENS_BITS-1){1'b1}}};
  localparam logic signed [TOKENS_BITS-1:0] TOK_MIN = {1'b1, {(TOKENS_BITS-1){1'b0}}};
  localparam logic [PROCESSOR_ID_BITS:0]    NUM_PROC_W = (PROCESSOR_ID_BITS+1)'(NUM_PROCESSORS);
  localparam int                            PAD_BITS = TOKENS_BITS + 1 - NEW_TOKENS_BITS;

  logic signed [TOKENS_BITS-1:0]   tokens_q    [NUM_PROCESSORS];
  logic signed [TOKENS_BITS-1:0]   threshold_q [NUM_PROCESSORS];
  logic        [DURATION_BITS-1:0] duration_q  [NUM_PROCESSORS];
  logic        [DURATION_BITS-1:0] remaining_q [NUM_PROCESSORS];
  logic                            active_q    [NUM_PROCESSORS];

  logic signed [TOKENS_BITS-1:0]   tokens_d, threshold_d;
  logic        [DURATION_BITS-1:0] duration_d, remaining_d;
  logic                            active_d;
  logic                            we;
  logic                            start_d, stop_d;

  logic                            valid_q, start_q, stop_q;
  logic [PROCESSOR_ID_BITS-1:0]    out_id_q;

  instr_e                          instr;
  logic                            id_valid;
  logic [PROCESSOR_ID_BITS-1:0]    sel_id;
  logic signed [TOKENS_BITS:0]     sum_ext;
  logic signed [TOKENS_BITS-1:0]   tokens_sat;

  assign instr    = instr_e'(instruction);
  assign id_valid = {1'b0, processor_id} < NUM_PROC_W;
  // Out-of-range ids are ignored; steer the read port to a legal entry anyway.
  assign sel_id   = id_valid ? processor_id : '0;

  // One extra bit holds any single good/bad update; a mismatch of the top two bits
  // means the result left the TOKENS_BITS signed range and must clamp.
  assign sum_ext = $signed({tokens_q[sel_id][TOKENS_BITS-1], tokens_q[sel_id]})
                 + $signed({{PAD_BITS{1'b0}}, new_good_tokens})
                 - $signed({{PAD_BITS{1'b0}}, new_bad_tokens});

  always_comb begin
    if (sum_ext[TOKENS_BITS] != sum_ext[TOKENS_BITS-1]) begin
      tokens_sat = sum_ext[TOKENS_BITS] ? TOK_MIN : TOK_MAX;
    end else begin
      tokens_sat = sum_ext[TOKENS_BITS-1:0];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    tokens_d    = tokens_q[sel_id];
    threshold_d = threshold_q[sel_id];
    duration_d  = duration_q[sel_id];
    remaining_d = remaining_q[sel_id];
    active_d    = active_q[sel_id];
    we          = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;

    if (id_valid) begin
      case (instr)
        INSTR_INIT: begin
          we          = 1'b1;
          threshold_d = prog_threshold;
          duration_d  = prog_duration;
          tokens_d    = '0;
          remaining_d = '0;
          active_d    = 1'b0;
        end
        INSTR_INPUT: begin
          we       = 1'b1;
          tokens_d = tokens_sat;
        end
        INSTR_TICK: begin
          we = 1'b1;
          if (active_q[sel_id]) begin
            remaining_d = (remaining_q[sel_id] == '0) ? '0
                                                      : remaining_q[sel_id] - DURATION_BITS'(1);
            if (remaining_q[sel_id] <= DURATION_BITS'(1)) begin
              active_d = 1'b0;
              stop_d   = 1'b1;
            end
          end else if (tokens_q[sel_id] >= threshold_q[sel_id]) begin
            tokens_d    = '0;
            remaining_d = duration_q[sel_id];
            active_d    = (duration_q[sel_id] != '0);
            start_d     = 1'b1;
            stop_d      = (duration_q[sel_id] == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-processor arrays are architectural state with defined reset values,
      // so they are cleared here rather than left to be initialised by INIT.
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        tokens_q[i]    <= '0;
        threshold_q[i] <= TOK_MAX;
        duration_q[i]  <= '0;
        remaining_q[i] <= '0;
        active_q[i]    <= 1'b0;
      end
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      out_id_q <= '0;
    end else begin
      if (we) begin
        tokens_q[sel_id]    <= tokens_d;
        threshold_q[sel_id] <= threshold_d;
        duration_q[sel_id]  <= duration_d;
        remaining_q[sel_id] <= remaining_d;
        active_q[sel_id]    <= active_d;
      end
      valid_q  <= start_d | stop_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      out_id_q <= (start_d | stop_d) ? processor_id : '0;
    end
  end

  assign output_valid = valid_q;
  assign token_start  = start_q;
  assign token_stop   = stop_q;
  assign output_id    = out_id_q;

endmodule

// File: tb/tb_ticktocktokens_core.sv
// Self-checking bench for ticktocktokens_core: a vector table plus hand-written
// multi-cycle sequences, with expected outputs queued at drive time.
module tb_ticktocktokens_core;

  localparam logic [1:0] NOP = 2'b00, INIT = 2'b01, INP = 2'b10, TICK = 2'b11;

  typedef struct {
    logic       rst;
    logic [1:0] instr;
    logic [3:0] id;
    logic [3:0] good;
    logic [3:0] bad;
    logic [7:0] thr;
    logic [7:0] dur;
    logic [6:0] exp;   // {valid, start, stop, id}
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] instruction;
  logic [3:0] processor_id;
  logic [3:0] new_good_tokens, new_bad_tokens;
  logic [7:0] prog_threshold, prog_duration;
  logic       output_valid, token_start, token_stop;
  logic [3:0] output_id;

  int         vectors = 0;
  int         miscompares = 0;
  logic [6:0] exp_q[$];
  vec_t       table_v[$];

  ticktocktokens_core dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .processor_id   (processor_id),
    .new_good_tokens(new_good_tokens),
    .new_bad_tokens (new_bad_tokens),
    .prog_threshold (prog_threshold),
    .prog_duration  (prog_duration),
    .output_valid   (output_valid),
    .token_start    (token_start),
    .token_stop     (token_stop),
    .output_id      (output_id)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] o(input logic v, input logic s, input logic p, input logic [3:0] id);
    return {v, s, p, id};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [1:0] instr, input logic [3:0] id,
                              input logic [3:0] good, input logic [3:0] bad,
                              input logic [7:0] thr, input logic [7:0] dur, input logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.instr = instr; v.id = id; v.good = good; v.bad = bad;
    v.thr = thr; v.dur = dur; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got valid/start/stop/id=%b/%b/%b/%0d, want %b/%b/%b/%0d",
               name, got[6], got[5], got[4], got[3:0], want[6], want[5], want[4], want[3:0]);
    end
  endtask

  // Called at a negedge: drive one instruction, queue its expectation, compare one cycle later.
  task automatic step(input string name, input vec_t v);
    logic [6:0] want;
    reset           = v.rst;
    instruction     = v.instr;
    processor_id    = v.id;
    new_good_tokens = v.good;
    new_bad_tokens  = v.bad;
    prog_threshold  = v.thr;
    prog_duration   = v.dur;
    exp_q.push_back(v.exp);
    vectors++;
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    check(name, {output_valid, token_start, token_stop, output_id}, want);
  endtask

  task automatic run(input string name, input logic [1:0] instr, input logic [3:0] id,
                     input logic [3:0] good, input logic [3:0] bad,
                     input logic [7:0] thr, input logic [7:0] dur, input logic [6:0] exp);
    step(name, mk(1'b0, instr, id, good, bad, thr, dur, exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; instruction = NOP; processor_id = '0;
    new_good_tokens = '0; new_bad_tokens = '0; prog_threshold = '0; prog_duration = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, unprogrammed ticks, then the basic fire/hold/stop scenario on id 3.
    table_v.push_back(mk(1, TICK, 4'd3, 0, 0, 0, 0, o(0, 0, 0, 0)));
    for (int i = 0; i < 10; i++)
      table_v.push_back(mk(0, TICK, 4'(i), 0, 0, 0, 0, o(0, 0, 0, 0)));
    table_v.push_back(mk(0, INIT, 4'd3, 0, 0, 8'd5, 8'd2, o(0, 0, 0, 0)));
    table_v.push_back(mk(0, INP,  4'd3, 3, 0, 0, 0, o(0, 0, 0, 0)));
    table_v.push_back(mk(0, INP,  4'd3, 3, 0, 0, 0, o(0, 0, 0, 0)));
    table_v.push_back(mk(0, TICK, 4'd3, 0, 0, 0, 0, o(1, 1, 0, 3)));
    table_v.push_back(mk(0, TICK, 4'd3, 0, 0, 0, 0, o(0, 0, 0, 0)));
    table_v.push_back(mk(0, TICK, 4'd3, 0, 0, 0, 0, o(1, 0, 1, 3)));
    table_v.push_back(mk(0, TICK, 4'd3, 0, 0, 0, 0, o(0, 0, 0, 0)));
    table_v.push_back(mk(0, NOP,  4'd3, 0, 0, 0, 0, o(0, 0, 0, 0)));
    foreach (table_v[i]) step($sformatf("table[%0d]", i), table_v[i]);

    // Positive saturation: 10 x 15 clamps at 127, so -15 then +15 lands exactly on 127.
    run("sat_pos_init", INIT, 0, 0, 0, 8'd127, 8'd1, o(0, 0, 0, 0));
    for (int i = 0; i < 10; i++) run("sat_pos_in", INP, 0, 15, 0, 0, 0, o(0, 0, 0, 0));
    run("sat_pos_sub", INP, 0, 0, 15, 0, 0, o(0, 0, 0, 0));
    run("sat_pos_tick_112", TICK, 0, 0, 0, 0, 0, o(0, 0, 0, 0));
    run("sat_pos_add", INP, 0, 15, 0, 0, 0, o(0, 0, 0, 0));
    run("sat_pos_fire", TICK, 0, 0, 0, 0, 0, o(1, 1, 0, 0));
    run("sat_pos_stop", TICK, 0, 0, 0, 0, 0, o(1, 0, 1, 0));

    // Negative saturation: clamps at -128, +15 gives -113 (below -112), +1 reaches it.
    run("sat_neg_init", INIT, 0, 0, 0, 8'h90, 8'd0, o(0, 0, 0, 0));
    for (int i = 0; i < 10; i++) run("sat_neg_in", INP, 0, 0, 15, 0, 0, o(0, 0, 0, 0));
    run("sat_neg_add15", INP, 0, 15, 0, 0, 0, o(0, 0, 0, 0));
    run("sat_neg_tick_m113", TICK, 0, 0, 0, 0, 0, o(0, 0, 0, 0));
    run("sat_neg_add1", INP, 0, 1, 0, 0, 0, o(0, 0, 0, 0));
    run("sat_neg_fire", TICK, 0, 0, 0, 0, 0, o(1, 1, 1, 0));

    // Zero duration: start and stop together, and it re-fires on the very next tick.
    run("dur0_init", INIT, 1, 0, 0, 8'd0, 8'd0, o(0, 0, 0, 0));
    run("dur0_fire", TICK, 1, 0, 0, 0, 0, o(1, 1, 1, 1));
    run("dur0_refire", TICK, 1, 0, 0, 0, 0, o(1, 1, 1, 1));

    // Reset while id 2 is active: outputs clear, no stop token, thresholds back to max.
    run("rst_init", INIT, 2, 0, 0, 8'd0, 8'd5, o(0, 0, 0, 0));
    run("rst_fire", TICK, 2, 0, 0, 0, 0, o(1, 1, 0, 2));
    step("rst_override", mk(1, TICK, 2, 0, 0, 0, 0, o(0, 0, 0, 0)));
    run("rst_tick2", TICK, 2, 0, 0, 0, 0, o(0, 0, 0, 0));
    run("rst_tick1", TICK, 1, 0, 0, 0, 0, o(0, 0, 0, 0));

    // Out-of-range id 12 is ignored and must not alias onto id 4.
    run("id12_init", INIT, 12, 0, 0, 8'd0, 8'd0, o(0, 0, 0, 0));
    run("id12_input", INP, 12, 15, 0, 0, 0, o(0, 0, 0, 0));
    run("id12_tick", TICK, 12, 0, 0, 0, 0, o(0, 0, 0, 0));
    run("id4_tick", TICK, 4, 0, 0, 0, 0, o(0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
